tdc_acq_sequencer: RTL and testbench
====================================

# tdc_acq_sequencer

Acquisition controller for the TDC capture path. It sequences the two stages of a measurement run. In the write stage it gates TDC timestamp strobes into the capture FIFO until a programmed hit count is reached. In the read stage it drains the FIFO word-by-word into the UART transmitter through a valid/ready handshake. It sits between the debounced front-panel start pulses, the TDC encoder's hit strobe, the capture FIFO and the UART framer, and it drives the four stage/error LEDs.

## Interface
Parameters:
- `N_HITS`, 300, hits accepted per write stage before automatic stop.
- `SETTLE_CYC`, 4, cycles to wait after leaving write before sampling `fifo_empty`. Covers async-FIFO flag latency.
- `CNT_W`, `$clog2(N_HITS+1)`, width of the hit and word counters.

Ports:
- `clk` in 1: system clock. All logic runs on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_wr` in 1: one-cycle pulse that starts the write stage.
- `start_rd` in 1: one-cycle pulse that starts the read stage.
- `hit_valid` in 1: one-cycle strobe from the TDC encoder; a timestamp is ready.
- `fifo_full` in 1: capture FIFO full flag.
- `fifo_empty` in 1: capture FIFO empty flag.
- `fifo_wr_en` out 1: FIFO write enable.
- `fifo_rd_en` out 1: FIFO read enable. FIFO data is valid one cycle later.
- `uart_valid` out 1: FIFO output word is offered to the UART.
- `uart_ready` in 1: UART accepts the word on the cycle where `uart_valid & uart_ready`.
- `hit_count` out CNT_W: hits accepted in the current or last write stage.
- `word_count` out CNT_W: words sent in the current or last read stage.
- `led_write_stage` out 1: high while in WRITE.
- `led_read_stage` out 1: high while in SETTLE, READ, LOAD or SEND.
- `led_write_err` out 1: sticky write error (hit lost).
- `led_read_err` out 1: sticky read error (read started with an empty FIFO).

## Operation
- **State reset:** on `rst`, all outputs, both counters and both error flags clear to 0, and the FSM enters IDLE.
- **IDLE:**
  - `start_wr` → WRITE. Clears `hit_count` and `led_write_err`.
  - `start_rd` → SETTLE. Clears `word_count` and `led_read_err`.
  - Both pulses in the same cycle: write wins.
- **WRITE:**
  - `fifo_wr_en = hit_valid & ~fifo_full`, combinational from the inputs. Each accepted hit increments `hit_count`.
  - `hit_valid & fifo_full` sets `led_write_err`. The FSM stays in WRITE.
  - Exit to IDLE on the cycle the N_HITS-th hit is accepted.
  - `start_rd` aborts the write stage → SETTLE. A hit arriving in that same cycle is still written.
  - `start_wr` in WRITE is ignored.
- **SETTLE:**
  - Counts `SETTLE_CYC` cycles, then samples `fifo_empty`.
  - Empty → IDLE and set `led_read_err`.
  - Not empty → READ.
- **READ:**
  - `fifo_empty` → IDLE (run complete).
  - Otherwise assert `fifo_rd_en` for one cycle → LOAD.
- **LOAD:** one cycle for FIFO data latency → SEND.
- **SEND:**
  - Hold `uart_valid` high until `uart_ready`.
  - On the handshake, increment `word_count` → READ.
- **Start pulses during read:** `start_wr`/`start_rd` in SETTLE, READ, LOAD or SEND are ignored.
- **Counter width:** counters saturate at N_HITS; no wrap-around.

## Timing
- `led_*` and the counters are registered.
- `uart_valid` is registered and decoded from state SEND.
- `fifo_rd_en` is combinational from state READ & ~fifo_empty, so it is never asserted on an empty FIFO.
- Write stage: zero-cycle latency from `hit_valid` to `fifo_wr_en`.
- Read stage: minimum 3 cycles per word (READ → LOAD → SEND with `uart_ready` already high).
- Start to first `fifo_rd_en`: SETTLE_CYC+1 cycles after the `start_rd` pulse.
- Asynchronous `rst` mid-run:
  - Every output drops immediately; no partial UART word remains asserted.
  - FIFO contents are not touched; the FIFO is reset separately.

## Structure
- Shared package `tdc_pkg`: state enum (IDLE, WRITE, SETTLE, READ, LOAD, SEND) and the default `N_HITS`/`SETTLE_CYC` constants, reused by the top-level and the bench.
- Single module with no sub-modules. The settle timer is an inline counter.

## Test plan
- Reset, then `start_wr`, then 300 `hit_valid` pulses with FIFO not full:
  - 300 `fifo_wr_en` pulses.
  - `hit_count` = 300.
  - IDLE on the 300th hit; `led_write_stage` falls the next cycle.
- In WRITE, `fifo_full` = 1 with 2 hits:
  - No `fifo_wr_en` for those hits.
  - `led_write_err` = 1, stays set until the next `start_wr`.
- `start_rd` with 5 words in the FIFO and `uart_ready` tied high:
  - First `fifo_rd_en` SETTLE_CYC+1 cycles after the pulse.
  - 5 words sent, `word_count` = 5, return to IDLE.
  - `led_read_err` = 0.
- `start_rd` with an empty FIFO:
  - After SETTLE_CYC cycles, `led_read_err` = 1 and IDLE.
  - Zero `fifo_rd_en` pulses.
- `uart_ready` held low 20 cycles in SEND:
  - `uart_valid` stays high and `word_count` is unchanged.
  - Advances one cycle after `uart_ready` rises.
- `rst` asserted mid-SEND, and `start_wr`/`start_rd` pulsed in the same cycle from IDLE:
  - `rst`: all outputs 0 immediately.
  - Simultaneous start pulses: FSM enters WRITE.

Source files
------------

// File: rtl/tdc_acq_sequencer_pkg.sv
// Shared definitions for the TDC acquisition sequencer: FSM state encoding
// and default run parameters used by the RTL and the bench.
package tdc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SETTLE,
        READ,
        LOAD,
        SEND
    } state_t;

    localparam int N_HITS_DEF     = 300;
    localparam int SETTLE_CYC_DEF = 4;

endpackage

// File: rtl/tdc_acq_sequencer_if.sv
// Control/status bundle between the acquisition sequencer and its surroundings
// (front-panel starts, TDC strobe, capture FIFO, UART framer, LEDs).
interface tdc_acq_sequencer_if
    import tdc_pkg::*;
#(
    parameter int CNT_W = $clog2(N_HITS_DEF + 1)
);

    logic             start_wr;
    logic             start_rd;
    logic             hit_valid;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_wr_en;
    logic             fifo_rd_en;
    logic             uart_valid;
    logic             uart_ready;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] word_count;
    logic             led_write_stage;
    logic             led_read_stage;
    logic             led_write_err;
    logic             led_read_err;

    modport master (
        input  start_wr, start_rd, hit_valid, fifo_full, fifo_empty, uart_ready,
        output fifo_wr_en, fifo_rd_en, uart_valid, hit_count, word_count,
               led_write_stage, led_read_stage, led_write_err, led_read_err
    );

    modport slave (
        output start_wr, start_rd, hit_valid, fifo_full, fifo_empty, uart_ready,
        input  fifo_wr_en, fifo_rd_en, uart_valid, hit_count, word_count,
               led_write_stage, led_read_stage, led_write_err, led_read_err
    );

endinterface

// File: rtl/tdc_acq_sequencer.sv
// Two-stage TDC acquisition controller: gates hit strobes into the capture FIFO,
// then drains the FIFO into the UART over a valid/ready handshake.
module tdc_acq_sequencer
    import tdc_pkg::*;
#(
    parameter int N_HITS     = N_HITS_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int CNT_W      = $clog2(N_HITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    tdc_acq_sequencer_if.master bus
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             wr_err_q, wr_err_d;
    logic             rd_err_q, rd_err_d;
    logic             uart_valid_q;
    logic             led_wr_q;
    logic             led_rd_q;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_W'(N_HITS)) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        hit_cnt_d  = hit_cnt_q;
        word_cnt_d = word_cnt_q;
        settle_d   = settle_q;
        wr_err_d   = wr_err_q;
        rd_err_d   = rd_err_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_wr) begin
                    state_d   = WRITE;
                    hit_cnt_d = '0;
                    wr_err_d  = 1'b0;
                end else if (bus.start_rd) begin
                    state_d    = SETTLE;
                    word_cnt_d = '0;
                    rd_err_d   = 1'b0;
                    settle_d   = '0;
                end
            end
            WRITE: begin
                wr_en = bus.hit_valid & ~bus.fifo_full;
                if (bus.hit_valid & bus.fifo_full) wr_err_d = 1'b1;
                if (wr_en) hit_cnt_d = sat_inc(hit_cnt_q);
                // An abort still lets the coincident hit through to the FIFO.
                if (bus.start_rd) begin
                    state_d    = SETTLE;
                    word_cnt_d = '0;
                    rd_err_d   = 1'b0;
                    settle_d   = '0;
                end else if (wr_en && (hit_cnt_q >= CNT_W'(N_HITS - 1))) begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                    if (bus.fifo_empty) begin
                        state_d  = IDLE;
                        rd_err_d = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            READ: begin
                if (bus.fifo_empty) begin
                    state_d = IDLE;
                end else begin
                    rd_en   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = SEND;
            SEND: begin
                if (bus.uart_ready) begin
                    word_cnt_d = sat_inc(word_cnt_q);
                    state_d    = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // LEDs and uart_valid are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            settle_q     <= '0;
            wr_err_q     <= 1'b0;
            rd_err_q     <= 1'b0;
            uart_valid_q <= 1'b0;
            led_wr_q     <= 1'b0;
            led_rd_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            hit_cnt_q    <= hit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            settle_q     <= settle_d;
            wr_err_q     <= wr_err_d;
            rd_err_q     <= rd_err_d;
            uart_valid_q <= (state_d == SEND);
            led_wr_q     <= (state_d == WRITE);
            led_rd_q     <= (state_d == SETTLE) || (state_d == READ) ||
                            (state_d == LOAD)   || (state_d == SEND);
        end
    end

    assign bus.fifo_wr_en      = wr_en;
    assign bus.fifo_rd_en      = rd_en;
    assign bus.uart_valid      = uart_valid_q;
    assign bus.hit_count       = hit_cnt_q;
    assign bus.word_count      = word_cnt_q;
    assign bus.led_write_stage = led_wr_q;
    assign bus.led_read_stage  = led_rd_q;
    assign bus.led_write_err   = wr_err_q;
    assign bus.led_read_err    = rd_err_q;

endmodule

// File: tb/tb_tdc_acq_sequencer.sv
// Bench for tdc_acq_sequencer: directed stimulus with a small FIFO occupancy model;
// expected hit/word counts are queued per transfer and checked by a monitor.
module tb_tdc_acq_sequencer;
    import tdc_pkg::*;

    localparam int N_HITS     = N_HITS_DEF;
    localparam int SETTLE_CYC = SETTLE_CYC_DEF;
    localparam int CNT_W      = $clog2(N_HITS + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    tdc_acq_sequencer_if #(.CNT_W(CNT_W)) bus ();

    tdc_acq_sequencer #(
        .N_HITS    (N_HITS),
        .SETTLE_CYC(SETTLE_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_seen = 0;
    int rd_seen = 0;
    int wr_q[$];
    int tx_q[$];
    int exp_v;

    // Capture FIFO occupancy model; fifo_set_* stands in for the FIFO's own reset.
    int   fifo_cnt     = 0;
    logic fifo_set_en  = 1'b0;
    int   fifo_set_val = 0;

    always @(posedge clk) begin
        if (fifo_set_en)
            fifo_cnt <= fifo_set_val;
        else
            fifo_cnt <= fifo_cnt + (bus.fifo_wr_en ? 1 : 0) - (bus.fifo_rd_en ? 1 : 0);
    end

    assign bus.fifo_empty = (fifo_cnt == 0);

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.fifo_wr_en) begin
                wr_seen++;
                n_tests++;
                if (wr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_unexpected: fifo_wr_en with hit_count=%0d, none expected", bus.hit_count);
                end else begin
                    exp_v = wr_q.pop_front();
                    if (bus.hit_count !== CNT_W'(exp_v)) begin
                        n_fail++;
                        $display("FAIL wr_hit_count: got %0d expected %0d", bus.hit_count, exp_v);
                    end
                end
            end
            if (bus.fifo_rd_en) rd_seen++;
            if (bus.uart_valid && bus.uart_ready) begin
                n_tests++;
                if (tx_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_unexpected: handshake with word_count=%0d, none expected", bus.word_count);
                end else begin
                    exp_v = tx_q.pop_front();
                    if (bus.word_count !== CNT_W'(exp_v)) begin
                        n_fail++;
                        $display("FAIL tx_word_count: got %0d expected %0d", bus.word_count, exp_v);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_set(input int v);
        fifo_set_en  = 1'b1;
        fifo_set_val = v;
        tick();
        fifo_set_en  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},     32'(bus.fifo_wr_en),      0);
        check({tag, "_rd_en"},     32'(bus.fifo_rd_en),      0);
        check({tag, "_uart_vld"},  32'(bus.uart_valid),      0);
        check({tag, "_hit_cnt"},   32'(bus.hit_count),       0);
        check({tag, "_word_cnt"},  32'(bus.word_count),      0);
        check({tag, "_led_wr"},    32'(bus.led_write_stage), 0);
        check({tag, "_led_rd"},    32'(bus.led_read_stage),  0);
        check({tag, "_led_werr"},  32'(bus.led_write_err),   0);
        check({tag, "_led_rerr"},  32'(bus.led_read_err),    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        bit found;

        bus.start_wr   = 1'b0;
        bus.start_rd   = 1'b0;
        bus.hit_valid  = 1'b0;
        bus.fifo_full  = 1'b0;
        bus.uart_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // Full write stage of N_HITS hits
        fifo_set(0);
        bus.start_wr = 1'b1;
        tick();
        bus.start_wr = 1'b0;
        @(negedge clk);
        check("t1_led_wr_on", 32'(bus.led_write_stage), 1);
        check("t1_hit_cnt0",  32'(bus.hit_count),       0);
        tick();
        for (int i = 0; i < N_HITS; i++) begin
            bus.hit_valid = 1'b1;
            wr_q.push_back(i);
            if (i == N_HITS - 1) begin
                @(negedge clk);
                check("t1_led_wr_last", 32'(bus.led_write_stage), 1);
            end
            tick();
        end
        bus.hit_valid = 1'b0;
        @(negedge clk);
        check("t1_hit_cnt",   32'(bus.hit_count),       N_HITS);
        check("t1_led_wr_off", 32'(bus.led_write_stage), 0);
        check("t1_wr_pulses", 32'(wr_seen),             N_HITS);
        tick();
        bus.hit_valid = 1'b1;
        tick();
        bus.hit_valid = 1'b0;
        @(negedge clk);
        check("t1_idle_hit_ignored", 32'(wr_seen),       N_HITS);
        check("t1_hit_cnt_hold",     32'(bus.hit_count), N_HITS);

        // Read stage started on an empty FIFO
        tick();
        fifo_set(0);
        base = rd_seen;
        bus.start_rd = 1'b1;
        tick();
        bus.start_rd = 1'b0;
        for (int k = 1; k <= SETTLE_CYC; k++) @(negedge clk);
        check("t2_rerr_before", 32'(bus.led_read_err),   0);
        check("t2_led_rd_on",   32'(bus.led_read_stage), 1);
        @(negedge clk);
        check("t2_rerr_set",    32'(bus.led_read_err),   1);
        check("t2_led_rd_off",  32'(bus.led_read_stage), 0);
        check("t2_no_rd_en",    32'(rd_seen - base),     0);
        check("t2_word_cnt",    32'(bus.word_count),     0);

        // Write with FIFO full, abort into read of 5 words
        tick();
        bus.start_wr = 1'b1;
        tick();
        bus.start_wr = 1'b0;
        @(negedge clk);
        check("t3_werr_clear",  32'(bus.led_write_err), 0);
        check("t3_hit_cnt0",    32'(bus.hit_count),     0);
        check("t3_rerr_sticky", 32'(bus.led_read_err),  1);
        base = wr_seen;
        tick();
        bus.fifo_full = 1'b1;
        bus.hit_valid = 1'b1;
        tick();
        tick();
        bus.fifo_full = 1'b0;
        bus.hit_valid = 1'b0;
        @(negedge clk);
        check("t3_werr_set",    32'(bus.led_write_err), 1);
        check("t3_full_no_wr",  32'(wr_seen - base),    0);
        check("t3_full_no_cnt", 32'(bus.hit_count),     0);
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.hit_valid = 1'b1;
            wr_q.push_back(i);
            tick();
        end
        bus.uart_ready = 1'b1;
        for (int i = 0; i < 5; i++) tx_q.push_back(i);
        base = rd_seen;
        bus.start_rd  = 1'b1;
        bus.hit_valid = 1'b1;
        wr_q.push_back(4);
        tick();
        bus.start_rd  = 1'b0;
        bus.hit_valid = 1'b0;
        found = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) begin
                found = 1'b1;
                break;
            end
        end
        check("t3_first_rd_latency", found ? 32'(n) : 32'hFFFF_FFFF, SETTLE_CYC + 1);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus.led_read_stage) begin
                found = 1'b1;
                break;
            end
        end
        check("t3_read_done",     32'(found),            1);
        check("t3_word_cnt",      32'(bus.word_count),   5);
        check("t3_rd_pulses",     32'(rd_seen - base),   5);
        check("t3_rerr_clear",    32'(bus.led_read_err), 0);
        check("t3_werr_sticky",   32'(bus.led_write_err), 1);
        check("t3_hit_cnt",       32'(bus.hit_count),    5);
        check("t3_fifo_drained",  32'(fifo_cnt),         0);

        // Back-pressure in SEND, then reset mid-SEND
        tick();
        fifo_set(2);
        bus.uart_ready = 1'b0;
        bus.start_rd   = 1'b1;
        tick();
        bus.start_rd   = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.uart_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_send_reached", 32'(found), 1);
        for (int j = 0; j < 20; j++) begin
            if (j > 0) @(negedge clk);
            check("t4_hold_valid", 32'(bus.uart_valid), 1);
            check("t4_hold_cnt",   32'(bus.word_count), 0);
        end
        tick();
        tx_q.push_back(0);
        bus.uart_ready = 1'b1;
        @(negedge clk);
        check("t4_valid_at_hs", 32'(bus.uart_valid), 1);
        tick();
        @(negedge clk);
        check("t4_adv_valid",   32'(bus.uart_valid),     0);
        check("t4_adv_cnt",     32'(bus.word_count),     1);
        check("t4_adv_led_rd",  32'(bus.led_read_stage), 1);
        tick();
        bus.uart_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.uart_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_second_send", 32'(found), 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t4_async_rst");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Simultaneous start pulses: write wins
        bus.start_wr = 1'b1;
        bus.start_rd = 1'b1;
        tick();
        bus.start_wr = 1'b0;
        bus.start_rd = 1'b0;
        @(negedge clk);
        check("t5_led_wr",  32'(bus.led_write_stage), 1);
        check("t5_led_rd",  32'(bus.led_read_stage),  0);
        check("t5_hit_cnt", 32'(bus.hit_count),       0);

        check("wr_q_drained", 32'(wr_q.size()), 0);
        check("tx_q_drained", 32'(tx_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
